// File: rtl/pf_sched_pkg.sv
// Shared types, default parameters and op-field helpers for the prefetch scheduler.
package pf_sched_pkg;

   typedef enum logic {
      PF_LVL_DC = 1'b0,
      PF_LVL_L2 = 1'b1
   } pf_lvl_e;

   localparam int unsigned PF_NPIPES        = 2;
   localparam int unsigned PF_OP_W          = 128;
   localparam int unsigned PF_LINE_LSB      = 6;
   localparam int unsigned PF_LINE_W        = 44;
   localparam int unsigned PF_LEVEL_BIT     = 127;
   localparam int unsigned PF_QDEPTH        = 4;
   localparam int unsigned PF_TOK_MAX       = 8;
   localparam int unsigned PF_REFILL_PERIOD = 4;

   // Widest op the helpers accept; callers zero-extend into it.
   localparam int unsigned PF_OP_W_MAX      = 256;

   // Line address field of an op (w must be below 64).
   function automatic logic [63:0] pf_line(input logic [PF_OP_W_MAX-1:0] op,
                                           input int unsigned lsb,
                                           input int unsigned w);
      return 64'(op >> lsb) & ((64'd1 << w) - 64'd1);
   endfunction

   // Destination pipe: low line-address bits (npipes is a power of two).
   function automatic logic [7:0] pf_pipe(input logic [63:0] line,
                                          input int unsigned npipes);
      return 8'(line & 64'(npipes - 1));
   endfunction

endpackage

// File: rtl/pfe_sched_if.sv
// Valid/retry channels of the scheduler: op input plus per-pipe DC and L2 request outputs.
interface pfe_sched_if
   import pf_sched_pkg::*;
#(
   parameter int unsigned NPIPES = PF_NPIPES,
   parameter int unsigned OP_W   = PF_OP_W
);
   logic                     in_valid;
   logic                     in_retry;
   logic [OP_W-1:0]          in_op;
   logic [NPIPES-1:0]        dc_req_valid;
   logic [NPIPES-1:0]        dc_req_retry;
   logic [NPIPES*OP_W-1:0]   dc_req;
   logic [NPIPES-1:0]        l2_req_valid;
   logic [NPIPES-1:0]        l2_req_retry;
   logic [NPIPES*OP_W-1:0]   l2_req;

   modport master (
      output in_valid, in_op, dc_req_retry, l2_req_retry,
      input  in_retry, dc_req_valid, dc_req, l2_req_valid, l2_req
   );

   modport slave (
      input  in_valid, in_op, dc_req_retry, l2_req_retry,
      output in_retry, dc_req_valid, dc_req, l2_req_valid, l2_req
   );
endinterface

// File: rtl/pf_sched_fifo.sv
// Input op FIFO with flush and a registered occupancy count.
module pf_sched_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 128
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers and count; flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/pfe_sched.sv
// Prefetch dispatch scheduler: queues ops, drops per-level back-to-back duplicate
// lines, rate-limits each level with a token bucket and steers ops to per-pipe staging.
module pfe_sched
   import pf_sched_pkg::*;
#(
   parameter int unsigned NPIPES        = PF_NPIPES,
   parameter int unsigned OP_W          = PF_OP_W,
   parameter int unsigned LINE_LSB      = PF_LINE_LSB,
   parameter int unsigned LINE_W        = PF_LINE_W,
   parameter int unsigned LEVEL_BIT     = PF_LEVEL_BIT,
   parameter int unsigned QDEPTH        = PF_QDEPTH,
   parameter int unsigned TOK_MAX       = PF_TOK_MAX,
   parameter int unsigned REFILL_PERIOD = PF_REFILL_PERIOD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sched_enable,
   input  logic        flush,
   pfe_sched_if.slave  bus,
   output logic [15:0] stat_dispatched,
   output logic [15:0] stat_dropped
);
   localparam int unsigned PIPE_W = $clog2(NPIPES);
   localparam int unsigned TOK_W  = $clog2(TOK_MAX + 1);
   localparam int unsigned RC_W   = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
   localparam int unsigned CNT_W  = $clog2(QDEPTH) + 1;

   logic [OP_W-1:0]   head;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_push;
   logic              fifo_pop;
   logic [CNT_W-1:0]  fifo_count;

   logic [LINE_W-1:0] line;
   logic [PIPE_W-1:0] pipe;
   logic              lvl_bit;
   pf_lvl_e           lvl;

   logic              head_ok;
   logic              dup;
   logic              chan_free;
   logic              disp;

   logic [NPIPES-1:0] stg_vld    [2];
   logic [OP_W-1:0]   stg_op     [2][NPIPES];
   logic [NPIPES-1:0] chan_retry [2];
   logic [NPIPES-1:0] xfer       [2];
   logic [NPIPES-1:0] load       [2];
   logic [1:0]        consume;

   logic [TOK_W-1:0]  tok [2];
   logic [RC_W-1:0]   ref_cnt;
   logic              refill;

   logic [LINE_W-1:0] last_line [2];
   logic [1:0]        last_vld;

   pf_sched_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (OP_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (flush),
      .din   (bus.in_op),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // in_retry depends only on the registered count, never on downstream retry.
   assign bus.in_retry = (fifo_count == CNT_W'(QDEPTH));
   assign fifo_push    = bus.in_valid && !fifo_full;
   assign fifo_pop     = dup || disp;

   assign line    = LINE_W'(pf_line(PF_OP_W_MAX'(head), LINE_LSB, LINE_W));
   assign pipe    = PIPE_W'(pf_pipe(64'(line), NPIPES));
   assign lvl_bit = head[LEVEL_BIT];
   assign lvl     = pf_lvl_e'(lvl_bit);
   assign refill  = (ref_cnt == RC_W'(REFILL_PERIOD - 1));

   // Per-channel transfer detection from staging valid and downstream retry.
   always_comb begin
      chan_retry[PF_LVL_DC] = bus.dc_req_retry;
      chan_retry[PF_LVL_L2] = bus.l2_req_retry;
      for (int unsigned l = 0; l < 2; l++) xfer[l] = stg_vld[l] & ~chan_retry[l];
   end

   // Head decision: duplicate drop beats dispatch; anything else stalls in order.
   always_comb begin
      head_ok   = !fifo_empty && sched_enable;
      dup       = head_ok && last_vld[lvl] && (line == last_line[lvl]);
      chan_free = !stg_vld[lvl][pipe] || xfer[lvl][pipe];
      disp      = head_ok && !dup && chan_free && (tok[lvl] != '0);
      consume   = '0;
      load[0]   = '0;
      load[1]   = '0;
      if (disp) begin
         consume[lvl_bit]    = 1'b1;
         load[lvl_bit][pipe] = 1'b1;
      end
   end

   // Drive the packed request buses from the staging registers.
   always_comb begin
      bus.dc_req_valid = stg_vld[PF_LVL_DC];
      bus.l2_req_valid = stg_vld[PF_LVL_L2];
      bus.dc_req       = '0;
      bus.l2_req       = '0;
      for (int unsigned p = 0; p < NPIPES; p++) begin
         bus.dc_req[p*OP_W +: OP_W] = stg_op[PF_LVL_DC][p];
         bus.l2_req[p*OP_W +: OP_W] = stg_op[PF_LVL_L2][p];
      end
   end

   // Staging registers: a load in the same cycle as a transfer keeps valid high.
   always_ff @(posedge clk) begin
      for (int unsigned l = 0; l < 2; l++) begin
         for (int unsigned p = 0; p < NPIPES; p++) begin
            if (reset) begin
               stg_vld[l][p] <= 1'b0;
               stg_op[l][p]  <= '0;
            end else if (load[l][p]) begin
               stg_vld[l][p] <= 1'b1;
               stg_op[l][p]  <= head;
            end else if (xfer[l][p]) begin
               stg_vld[l][p] <= 1'b0;
            end
         end
      end
   end

   // Token buckets with a shared refill tick; refill plus consume leaves a bucket unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         ref_cnt <= '0;
         for (int unsigned l = 0; l < 2; l++) tok[l] <= TOK_W'(TOK_MAX);
      end else begin
         ref_cnt <= refill ? '0 : ref_cnt + 1'b1;
         for (int unsigned l = 0; l < 2; l++) begin
            if (consume[l] && !refill)
               tok[l] <= tok[l] - 1'b1;
            else if (refill && !consume[l] && tok[l] != TOK_W'(TOK_MAX))
               tok[l] <= tok[l] + 1'b1;
         end
      end
   end

   // Duplicate filter state and saturating statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_vld        <= '0;
         last_line[0]    <= '0;
         last_line[1]    <= '0;
         stat_dispatched <= '0;
         stat_dropped    <= '0;
      end else begin
         if (disp) begin
            last_line[lvl_bit] <= line;
            last_vld[lvl_bit]  <= 1'b1;
         end
         if (disp && stat_dispatched != '1) stat_dispatched <= stat_dispatched + 16'd1;
         if (dup && stat_dropped != '1)     stat_dropped    <= stat_dropped + 16'd1;
      end
   end
endmodule

// File: tb/tb_pfe_sched.sv
// Scoreboard bench for pfe_sched: directed scenarios plus randomized traffic,
// expected per-channel op streams come from a list-level reference model.
module tb_pfe_sched;
   localparam int unsigned NP   = 2;
   localparam int unsigned OPW  = 128;
   localparam int unsigned QD   = 4;
   localparam int unsigned TOKM = 8;
   localparam int unsigned RP   = 4;

   typedef logic [OPW-1:0] op_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        sched_enable;
   logic        flush;
   logic [15:0] stat_dispatched;
   logic [15:0] stat_dropped;

   pfe_sched_if #(.NPIPES(NP), .OP_W(OPW)) bus ();

   pfe_sched #(
      .NPIPES        (NP),
      .OP_W          (OPW),
      .LINE_LSB      (6),
      .LINE_W        (44),
      .LEVEL_BIT     (127),
      .QDEPTH        (QD),
      .TOK_MAX       (TOKM),
      .REFILL_PERIOD (RP)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .sched_enable    (sched_enable),
      .flush           (flush),
      .bus             (bus),
      .stat_dispatched (stat_dispatched),
      .stat_dropped    (stat_dropped)
   );

   always #5 clk = ~clk;

   // Reference model state: expected op stream per (level, pipe) channel.
   op_t         expq [2*NP][$];
   logic [43:0] m_last [2];
   bit          m_vld [2];
   int          exp_disp;
   int          exp_drop;
   int          n_cmp;
   int          n_err;
   bit          rnd_on;
   bit          rec_on;
   int          cyc;
   int          tcyc [$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic op_t mk_op(input bit lvl, input logic [43:0] line);
      op_t o;
      o = {$urandom, $urandom, $urandom, $urandom};
      o[6 +: 44] = line;
      o[127] = lvl;
      return o;
   endfunction

   function automatic int pending();
      int s;
      s = 0;
      for (int i = 0; i < 2*NP; i++) s += expq[i].size();
      return s;
   endfunction

   // Ops leave the queue in acceptance order, so filtering is decided against the
   // previous surviving line of the same level.
   task automatic model_accept(input op_t op);
      bit          lvl;
      logic [43:0] line;
      int          ch;
      lvl  = op[127];
      line = op[6 +: 44];
      ch   = int'(lvl) * NP + int'(line % NP);
      if (m_vld[lvl] && m_last[lvl] == line) begin
         exp_drop++;
      end else begin
         expq[ch].push_back(op);
         exp_disp++;
         m_last[lvl] = line;
         m_vld[lvl]  = 1'b1;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2*NP; i++) expq[i].delete();
      m_vld[0] = 1'b0;
      m_vld[1] = 1'b0;
      exp_disp = 0;
      exp_drop = 0;
   endtask

   task automatic jitter();
      bus.dc_req_retry = NP'($urandom) & NP'($urandom);
      bus.l2_req_retry = NP'($urandom) & NP'($urandom);
      sched_enable     = ($urandom % 8) != 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         if (rnd_on) jitter();
      end
   endtask

   task automatic send(input op_t op);
      bit acc;
      int k;
      acc = 1'b0;
      k   = 0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      while (!acc && k < 300) begin
         @(negedge clk);
         acc = !bus.in_retry && !flush;
         @(posedge clk); #1;
         if (rnd_on) jitter();
         k++;
      end
      bus.in_valid = 1'b0;
      if (acc) model_accept(op);
      else begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got no accept expected accept of line %h", op[6 +: 44]);
      end
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (pending() != 0 && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      chk({name, "_drain"}, pending(), 0);
      repeat (8) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every transfer on a request channel pops and compares the expected op.
   logic mon_v;
   logic mon_r;
   op_t  mon_d;
   op_t  mon_e;
   int   mon_ch;
   always @(negedge clk) begin
      if (!reset) begin
         for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < NP; p++) begin
               mon_v = (l == 1) ? bus.l2_req_valid[p] : bus.dc_req_valid[p];
               mon_r = (l == 1) ? bus.l2_req_retry[p] : bus.dc_req_retry[p];
               mon_d = (l == 1) ? bus.l2_req[p*OPW +: OPW] : bus.dc_req[p*OPW +: OPW];
               if (mon_v && !mon_r) begin
                  mon_ch = l * NP + p;
                  if (expq[mon_ch].size() == 0) begin
                     n_cmp++;
                     n_err++;
                     $display("FAIL unexpected_xfer ch%0d: got %h expected none", mon_ch, mon_d);
                  end else begin
                     mon_e = expq[mon_ch].pop_front();
                     chk($sformatf("xfer_ch%0d", mon_ch), mon_d, mon_e);
                  end
                  if (l == 0 && rec_on) tcyc.push_back(cyc);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      op_t         op;
      op_t         first_op;
      logic [43:0] s_last;
      bit          s_vld;
      int          s_disp;
      int          s_sz;
      int          bad;

      cyc = 0;
      n_cmp = 0;
      n_err = 0;
      rnd_on = 1'b0;
      rec_on = 1'b0;
      reset = 1'b1;
      flush = 1'b0;
      sched_enable = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_op = '0;
      bus.dc_req_retry = '0;
      bus.l2_req_retry = '0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_dc_valid", bus.dc_req_valid, 0);
      chk("rst_l2_valid", bus.l2_req_valid, 0);
      chk("rst_in_retry", bus.in_retry, 0);
      chk("rst_stat_disp", stat_dispatched, 0);
      chk("rst_stat_drop", stat_dropped, 0);
      reset = 1'b0;

      // Single DC op, line 0x101 -> pipe 1, valid two cycles after acceptance.
      op = mk_op(1'b0, 44'h101);
      send(op);
      chk("lat_t1_valid", bus.dc_req_valid, 0);
      @(posedge clk); #1;
      chk("lat_t2_valid", bus.dc_req_valid[1], 1);
      chk("lat_t2_data", bus.dc_req[OPW +: OPW], op);
      drain("lat");
      chk("lat_stat_disp", stat_dispatched, exp_disp);

      // Back-to-back duplicate L2 line, then the same line on DC.
      send(mk_op(1'b1, 44'h200));
      send(mk_op(1'b1, 44'h200));
      send(mk_op(1'b0, 44'h200));
      drain("dup");
      chk("dup_stat_drop", stat_dropped, exp_drop);
      chk("dup_stat_disp", stat_dispatched, exp_disp);

      // Backpressure on DC pipe 0: one op staged, four fill the FIFO.
      bus.dc_req_retry = 2'b01;
      for (int i = 0; i < 5; i++) send(mk_op(1'b0, 44'h300 + 44'(2*i)));
      chk("bp_in_retry_full", bus.in_retry, 1);
      idle(4);
      chk("bp_in_retry_hold", bus.in_retry, 1);
      chk("bp_staged", bus.dc_req_valid[0], 1);
      bus.dc_req_retry = '0;
      drain("bp");

      // Flush with three queued ops behind a stuck staging register.
      bus.dc_req_retry = 2'b01;
      send(mk_op(1'b0, 44'h400));
      s_last = m_last[0];
      s_vld  = m_vld[0];
      s_disp = exp_disp;
      s_sz   = expq[0].size();
      for (int i = 1; i < 4; i++) send(mk_op(1'b0, 44'h400 + 44'(2*i)));
      idle(1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      while (expq[0].size() > s_sz) void'(expq[0].pop_back());
      exp_disp  = s_disp;
      m_last[0] = s_last;
      m_vld[0]  = s_vld;
      chk("flush_in_retry", bus.in_retry, 0);
      chk("flush_staged", bus.dc_req_valid[0], 1);
      chk("flush_stat_disp", stat_dispatched, exp_disp);
      idle(2);
      bus.dc_req_retry = '0;
      drain("flush");
      chk("flush_stat_after", stat_dispatched, exp_disp);
      send(mk_op(1'b0, 44'h406));
      drain("post_flush");

      // Randomized traffic: random level, small line set, random retry and enable.
      rnd_on = 1'b1;
      for (int i = 0; i < 150; i++) begin
         send(mk_op(1'($urandom), 44'h700 + 44'($urandom_range(0, 3))));
         idle($urandom_range(0, 2));
      end
      rnd_on = 1'b0;
      bus.dc_req_retry = '0;
      bus.l2_req_retry = '0;
      sched_enable = 1'b1;
      drain("rand");
      chk("rand_stat_disp", stat_dispatched, exp_disp);
      chk("rand_stat_drop", stat_dropped, exp_drop);

      // Reset in the middle of a stuck burst.
      bus.dc_req_retry = '1;
      for (int i = 0; i < 5; i++) send(mk_op(1'b0, 44'h800 + 44'(2*i)));
      chk("pre_rst_in_retry", bus.in_retry, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_dc_valid", bus.dc_req_valid, 0);
      chk("mid_rst_l2_valid", bus.l2_req_valid, 0);
      chk("mid_rst_in_retry", bus.in_retry, 0);
      chk("mid_rst_stat_disp", stat_dispatched, 0);
      chk("mid_rst_stat_drop", stat_dropped, 0);
      model_reset();
      reset = 1'b0;
      bus.dc_req_retry = '0;

      // Token-limited burst of 16 distinct DC lines; the first reuses the pre-reset line.
      tcyc.delete();
      rec_on = 1'b1;
      first_op = mk_op(1'b0, 44'h800);
      send(first_op);
      for (int i = 1; i < 16; i++) send(mk_op(1'b0, 44'h800 + 44'(i)));
      drain("burst");
      rec_on = 1'b0;
      chk("burst_count", tcyc.size(), 16);
      chk("burst_stat_disp", stat_dispatched, exp_disp);
      chk("burst_stat_drop", stat_dropped, 0);
      if (tcyc.size() == 16) begin
         for (int i = 0; i < 7; i++) chk($sformatf("burst_gap%0d", i), tcyc[i+1] - tcyc[i], 1);
         for (int i = 13; i < 16; i++) chk($sformatf("burst_gap%0d", i - 1), tcyc[i] - tcyc[i-1], RP);
         bad = 0;
         for (int i = 0; i < 16; i++)
            for (int j = i; j < 16; j++)
               if ((j - i + 1) > TOKM + (tcyc[j] - tcyc[i]) / RP + 1) bad++;
         chk("burst_bucket_bound", bad, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
